// File: rtl/card_pkg.sv
// Shared types and helpers for the baccarat card dealer: deal-order states,
// the empty-slot code and the baccarat point arithmetic.
package card_pkg;

  typedef enum logic [2:0] {
    S_P1   = 3'd0,
    S_D1   = 3'd1,
    S_P2   = 3'd2,
    S_D2   = 3'd3,
    S_P3   = 3'd4,
    S_D3   = 3'd5,
    S_DONE = 3'd6
  } deal_state_t;

  localparam logic [3:0] CARD_EMPTY = 4'd0;
  localparam int         NUM_SLOTS  = 6;

  // Tens and face cards count zero in baccarat; an empty slot counts zero too.
  function automatic logic [3:0] card_value(input logic [3:0] code);
    return (code >= 4'd10) ? 4'd0 : code;
  endfunction

  function automatic logic [3:0] mod10_sum(input logic [3:0] a,
                                           input logic [3:0] b,
                                           input logic [3:0] c);
    logic [4:0] sum;
    sum = {1'b0, card_value(a)} + {1'b0, card_value(b)} + {1'b0, card_value(c)};
    if (sum >= 5'd20)      sum = sum - 5'd20;
    else if (sum >= 5'd10) sum = sum - 5'd10;
    return sum[3:0];
  endfunction

endpackage

// File: rtl/card_counter.sv
// Free-running 1..CARD_MAX rank counter used as the shuffle source.
module card_counter #(
  parameter int CARD_MAX = 13
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] card
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 4'd1;
    if (cnt_q == 4'(CARD_MAX)) cnt_d = 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 4'd1;
    else       cnt_q <= cnt_d;
  end

  assign card = cnt_q;

endmodule

// File: rtl/card_dealer.sv
// Deals counter snapshots into six card slots in baccarat order on each
// button rising edge, and scores both hands modulo 10.
module card_dealer
  import card_pkg::*;
#(
  parameter int CARD_MAX = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       next_card,
  input  logic       deal_p3,
  input  logic       deal_d3,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic       done
);

  if (CARD_MAX < 10 || CARD_MAX > 15) begin : g_bad_param
    $error("card_dealer: CARD_MAX must be in 10..15");
  end

  logic [3:0]                      card_cnt;
  logic                            next_card_q;
  logic                            deal_evt;
  logic                            load_en;
  logic [2:0]                      slot_sel;
  deal_state_t                     state_q, state_d;
  logic [NUM_SLOTS-1:0][3:0]       slot_q;

  card_counter #(.CARD_MAX(CARD_MAX)) u_counter (
    .clk   (clk),
    .reset (reset),
    .card  (card_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) next_card_q <= 1'b0;
    else       next_card_q <= next_card;
  end

  assign deal_evt = next_card & ~next_card_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_P1;
    else       state_q <= state_d;
  end

  // Third-card skips advance unconditionally and swallow any coincident press.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_P1:    if (deal_evt)             state_d = S_D1;
      S_D1:    if (deal_evt)             state_d = S_P2;
      S_P2:    if (deal_evt)             state_d = S_D2;
      S_D2:    if (deal_evt)             state_d = S_P3;
      S_P3:    if (!deal_p3 || deal_evt) state_d = S_D3;
      S_D3:    if (!deal_d3 || deal_evt) state_d = S_DONE;
      default:                           state_d = S_DONE;
    endcase
  end

  always_comb begin
    load_en = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_P1, S_D1, S_P2, S_D2: load_en = deal_evt;
      S_P3:                   load_en = deal_evt & deal_p3;
      S_D3:                   load_en = deal_evt & deal_d3;
      default:                done    = 1'b1;
    endcase
  end

  // State encoding doubles as the slot index for S_P1..S_D3.
  assign slot_sel = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= {NUM_SLOTS{CARD_EMPTY}};
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (load_en && slot_sel == 3'(i)) slot_q[i] <= card_cnt;
      end
    end
  end

  assign pcard1 = slot_q[0];
  assign dcard1 = slot_q[1];
  assign pcard2 = slot_q[2];
  assign dcard2 = slot_q[3];
  assign pcard3 = slot_q[4];
  assign dcard3 = slot_q[5];

  assign pscore = mod10_sum(pcard1, pcard2, pcard3);
  assign dscore = mod10_sum(dcard1, dcard2, dcard3);

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer against a slot-index reference model.
module tb_card_dealer;

  localparam int CARD_MAX = 13;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       next_card = 1'b0;
  logic       deal_p3 = 1'b1;
  logic       deal_d3 = 1'b1;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic [3:0] pscore, dscore;
  logic       done;

  int checks = 0;
  int errors = 0;

  card_dealer #(.CARD_MAX(CARD_MAX)) dut (
    .clk(clk), .reset(reset), .next_card(next_card),
    .deal_p3(deal_p3), .deal_d3(deal_d3),
    .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
    .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
    .pscore(pscore), .dscore(dscore), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: next slot index, the counter value, the previous button level.
  int m_cnt = 1;
  int m_slot = 0;
  bit m_prev = 1'b0;
  bit m_evt;
  int m_cards[6];

  always @(posedge clk) begin
    if (reset) begin
      m_cnt = 1; m_prev = 1'b0; m_slot = 0;
      foreach (m_cards[i]) m_cards[i] = 0;
    end else begin
      m_evt = next_card && !m_prev;
      if (m_slot == 4 && !deal_p3)      m_slot = 5;
      else if (m_slot == 5 && !deal_d3) m_slot = 6;
      else if (m_slot < 6 && m_evt) begin
        m_cards[m_slot] = m_cnt;
        m_slot++;
      end
      m_prev = next_card;
      m_cnt  = (m_cnt == CARD_MAX) ? 1 : m_cnt + 1;
    end
  end

  wire [23:0] dut_cards = {pcard1, dcard1, pcard2, dcard2, pcard3, dcard3};

  function automatic logic [23:0] m_vec();
    logic [23:0] v;
    for (int i = 0; i < 6; i++) v[23-4*i -: 4] = 4'(m_cards[i]);
    return v;
  endfunction

  function automatic int m_score(input int first);
    int s = 0;
    for (int i = first; i < 6; i += 2)
      s += (m_cards[i] <= 9) ? m_cards[i] : 0;
    return s % 10;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    next_card = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Press so that the deal edge samples counter value 'target'.
  task automatic press_at(input int target);
    int n = 0;
    next_card = 1'b0;
    do begin
      tick();
      n++;
    end while (m_cnt != target && n < 40);
    if (m_cnt != target) begin
      errors++;
      $display("FAIL press_at_timeout counter %0d required %0d", m_cnt, target);
    end
    next_card = 1'b1;
    tick();
    next_card = 1'b0;
  endtask

  task automatic press_rand();
    next_card = 1'b0;
    repeat ($urandom_range(1, 15)) tick();
    next_card = 1'b1;
    tick();
    next_card = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_cards !== 24'h0) begin
      errors++; $display("FAIL reset_cards got %h required 000000", dut_cards);
    end
    checks++;
    if ({pscore, dscore, done} !== 9'h0) begin
      errors++; $display("FAIL reset_scores got %h required 000", {pscore, dscore, done});
    end
  endtask

  task automatic test_basic_capture();
    do_reset();
    repeat (4) tick();
    next_card = 1'b1;
    tick();
    next_card = 1'b0;
    checks++;
    if (dut_cards !== 24'h500000) begin
      errors++; $display("FAIL basic_cards got %h required 500000", dut_cards);
    end
    checks++;
    if (pscore !== 4'd5 || dscore !== 4'd0 || done !== 1'b0) begin
      errors++; $display("FAIL basic_score got p%0d d%0d done%0d required p5 d0 done0", pscore, dscore, done);
    end
    tick();
    next_card = 1'b1;
    tick();
    next_card = 1'b0;
    checks++;
    if (dcard1 !== 4'(m_cards[1]) || pcard2 !== 4'd0 || m_cards[1] == 0) begin
      errors++; $display("FAIL basic_second_slot got d1=%0d p2=%0d required d1=%0d p2=0", dcard1, pcard2, m_cards[1]);
    end
  endtask

  task automatic test_full_hand();
    int tgt[6] = '{9, 13, 8, 12, 7, 3};
    do_reset();
    deal_p3 = 1'b1; deal_d3 = 1'b1;
    foreach (tgt[i]) press_at(tgt[i]);
    checks++;
    if (dut_cards !== 24'h9D8C73) begin
      errors++; $display("FAIL full_cards got %h required 9d8c73", dut_cards);
    end
    checks++;
    if (pscore !== 4'd4 || dscore !== 4'd3) begin
      errors++; $display("FAIL full_scores got p%0d d%0d required p4 d3", pscore, dscore);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL full_done got %0d required 1", done);
    end
    press_rand();
    tick();
    checks++;
    if (dut_cards !== 24'h9D8C73 || done !== 1'b1) begin
      errors++; $display("FAIL done_hold got %h done%0d required 9d8c73 done1", dut_cards, done);
    end
  endtask

  task automatic test_skip_third();
    do_reset();
    deal_p3 = 1'b0; deal_d3 = 1'b0;
    repeat (4) press_rand();
    checks++;
    if (done !== 1'b0 || dut_cards !== m_vec()) begin
      errors++; $display("FAIL skip_four got %h done%0d required %h done0", dut_cards, done, m_vec());
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL skip_one_cycle done got %0d required 0", done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || pcard3 !== 4'd0 || dcard3 !== 4'd0) begin
      errors++; $display("FAIL skip_done got done%0d p3=%0d d3=%0d required done1 p3=0 d3=0", done, pcard3, dcard3);
    end
    checks++;
    if (pscore !== 4'(m_score(0)) || dscore !== 4'(m_score(1))) begin
      errors++; $display("FAIL skip_scores got p%0d d%0d required p%0d d%0d", pscore, dscore, m_score(0), m_score(1));
    end
    deal_p3 = 1'b1; deal_d3 = 1'b1;
  endtask

  task automatic test_held_button();
    do_reset();
    next_card = 1'b1;
    repeat (20) tick();
    checks++;
    if (pcard1 !== 4'd1 || dcard1 !== 4'd0) begin
      errors++; $display("FAIL held_once got p1=%0d d1=%0d required p1=1 d1=0", pcard1, dcard1);
    end
    next_card = 1'b0;
    tick();
    next_card = 1'b1;
    tick();
    next_card = 1'b0;
    checks++;
    if (dcard1 !== 4'(m_cards[1]) || dcard1 === 4'd0) begin
      errors++; $display("FAIL held_repress got d1=%0d required %0d", dcard1, m_cards[1]);
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    press_rand();
    repeat (12) tick();
    next_card = 1'b1;
    tick();
    next_card = 1'b0;
    checks++;
    if (dcard1 !== pcard1 || dcard1 !== 4'(m_cards[1])) begin
      errors++; $display("FAIL wrap_13_apart got p1=%0d d1=%0d required both %0d", pcard1, dcard1, m_cards[0]);
    end
    press_at(CARD_MAX);
    repeat (13) tick();
    next_card = 1'b1;
    tick();
    next_card = 1'b0;
    checks++;
    if (pcard2 !== 4'd13 || dcard2 !== 4'd1) begin
      errors++; $display("FAIL wrap_to_one got p2=%0d d2=%0d required p2=13 d2=1", pcard2, dcard2);
    end
    repeat (2) press_rand();
    checks++;
    if (dut_cards !== m_vec() || pcard3 == 4'd0 || dcard3 == 4'd0 || done !== 1'b1) begin
      errors++; $display("FAIL wrap_no_zero got %h done%0d required %h done1", dut_cards, done, m_vec());
    end
  endtask

  task automatic test_reset_mid_hand();
    do_reset();
    repeat (3) press_rand();
    checks++;
    if (dut_cards !== m_vec() || pcard2 === 4'd0) begin
      errors++; $display("FAIL mid_pre got %h required %h", dut_cards, m_vec());
    end
    next_card = 1'b0;
    tick();
    reset = 1'b1;
    next_card = 1'b1;
    tick();
    reset = 1'b0;
    next_card = 1'b0;
    checks++;
    if (dut_cards !== 24'h0 || {pscore, dscore, done} !== 9'h0) begin
      errors++; $display("FAIL mid_reset got %h %h required 000000 000", dut_cards, {pscore, dscore, done});
    end
    do_reset();
    next_card = 1'b1;
    tick();
    next_card = 1'b0;
    checks++;
    if (pcard1 !== 4'd1 || dcard1 !== 4'd0) begin
      errors++; $display("FAIL mid_counter_restart got p1=%0d d1=%0d required p1=1 d1=0", pcard1, dcard1);
    end
  endtask

  task automatic test_random_hands();
    for (int h = 0; h < 6; h++) begin
      do_reset();
      deal_p3 = 1'($urandom_range(0, 1));
      deal_d3 = 1'($urandom_range(0, 1));
      for (int c = 0; c < 80; c++) begin
        next_card = ($urandom_range(0, 3) == 0);
        tick();
        checks++;
        if (dut_cards !== m_vec() || pscore !== 4'(m_score(0)) ||
            dscore !== 4'(m_score(1)) || done !== (m_slot == 6)) begin
          errors++;
          $display("FAIL random_h%0d_c%0d got %h p%0d d%0d done%0d required %h p%0d d%0d done%0d",
                   h, c, dut_cards, pscore, dscore, done, m_vec(), m_score(0), m_score(1), m_slot == 6);
        end
      end
    end
    next_card = 1'b0;
    deal_p3 = 1'b1; deal_d3 = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_full_hand();
    test_skip_third();
    test_held_button();
    test_counter_wrap();
    test_reset_mid_hand();
    test_random_hands();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
